// File: rtl/apb_pkg.sv
// Shared definitions for the APB master controller.
// Holds the FSM state type and default widths.
package apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts consecutive wait cycles in the ACCESS phase.
// at_limit flags that the next wait cycle is the last one allowed.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int LIMIT = APB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

    logic [CW-1:0] cnt;

    assign at_limit = (LIMIT > 0) && (cnt == LAST);

    // Wait-cycle counter, saturating so a disabled limit never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: turns local requests into SETUP/ACCESS transfers.
// Completes on PREADY, or aborts with an error after too many waits.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e state;
    apb_state_e state_next;

    logic accept;
    logic complete;
    logic timeout;
    logic at_limit;
    logic cnt_clr;
    logic cnt_inc;

    assign accept   = req_valid && req_ready;
    assign cnt_clr  = (state == SETUP);
    assign cnt_inc  = (state == ACCESS) && !PREADY;
    assign complete = (state == ACCESS) && PREADY;
    assign timeout  = cnt_inc && at_limit;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk      (pclk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .at_limit (at_limit)
    );

    // State register
    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and APB phase strobes
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                PSEL       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (complete || timeout) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request; held until the next accept
    always_ff @(posedge pclk) begin
        if (rst) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (accept) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_wdata;
        end
    end

    // Response pulse; data and error held until the next response
    always_ff @(posedge pclk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= complete || timeout;
            if (complete) begin
                rsp_err   <= PSLVERR;
                rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            end else if (timeout) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl.
// Emulates an APB slave and predicts each transfer at transaction level.
module tb_apb_master_ctrl;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    logic        last_err;
    logic [31:0] last_rd;

    always #5 pclk = ~pclk;

    apb_master_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Idle cycles: no pulse, response fields held, bus deselected
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_rspv", rsp_valid, 0);
            check("idle_err", rsp_err, last_err);
            check("idle_rdata", rsp_rdata, last_rd);
            check("idle_psel", PSEL, 0);
        end
    endtask

    // One full transfer; slave inserts w wait states
    task automatic xfer(input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int w, input bit serr);
        bit          to;
        int          exp_n;
        bit          exp_err;
        logic [31:0] exp_rd;
        int          k;
        bit          done;
        to      = (TO > 0) && (w >= TO);
        exp_n   = to ? TO : w + 1;
        exp_err = to || serr;
        exp_rd  = (!wr && !exp_err) ? rd : 32'h0;

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        check("req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        check("setup_psel", PSEL, 1);
        check("setup_pen", PENABLE, 0);
        check("setup_paddr", PADDR, a);
        check("setup_pwrite", PWRITE, wr);
        if (wr) check("setup_pwdata", PWDATA, wd);
        check("setup_ready", req_ready, 0);
        tick();
        k    = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            k++;
            check("acc_pen", PENABLE, 1);
            check("acc_paddr", PADDR, a);
            check("acc_rspv", rsp_valid, 0);
            PREADY  = (k == w + 1);
            PSLVERR = PREADY && serr;
            PRDATA  = PREADY ? rd : $urandom;
            tick();
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            done    = !PSEL;
        end
        check("acc_cycles", k, exp_n);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("done_pen", PENABLE, 0);
        check("done_ready", req_ready, 1);
        last_err = exp_err;
        last_rd  = exp_rd;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        last_err  = 1'b0;
        last_rd   = '0;

        tick();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_psel", PSEL, 0);
        check("rst_pen", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_rspv", rsp_valid, 0);
        check("rst_err", rsp_err, 0);
        check("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1);

        // Directed: write, waited read, slave error, timeout, edge
        xfer(1'b1, 32'h10, 32'h8000_0000, 32'h0, 0, 1'b0);
        idle(2);
        xfer(1'b0, 32'h24, 32'h0, 32'h7FFF_FFFF, 3, 1'b0);
        idle(1);
        xfer(1'b0, 32'h30, 32'h0, 32'h1234_5678, 0, 1'b1);
        idle(1);
        xfer(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 10, 1'b0);
        idle(1);
        xfer(1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, TO - 1, 1'b0);
        // Back-to-back writes, no gap after completion
        xfer(1'b1, 32'h50, 32'h1111_1111, 32'h0, 0, 1'b0);
        xfer(1'b1, 32'h54, 32'h2222_2222, 32'h0, 0, 1'b0);
        idle(1);

        // Reset in the middle of ACCESS
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h88;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_acc_pen", PENABLE, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_psel", PSEL, 0);
        check("mid_rst_rspv", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_paddr", PADDR, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready2", req_ready, 1);
        last_err = 1'b0;
        last_rd  = '0;
        idle(2);

        // Random transfers against the transaction model
        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 6), ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles with PREADY low (0 = timeout disabled).
REQ-004 SHALL have port pclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  local side presents a transfer request.
REQ-007 SHALL have port req_ready  output  1  controller accepts the request this cycle.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  transfer address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse: transfer complete.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data (0 for writes and errors).
REQ-013 SHALL have port rsp_err  output  1  PSLVERR seen or timeout.
REQ-014 SHALL have APB master ports: PADDR (ADDR_W), PSEL, PENABLE, PWRITE, PWDATA (DATA_W) as outputs; PRDATA (DATA_W), PREADY, PSLVERR as inputs.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, SETUP, ACCESS.
REQ-016 SHALL drive req_ready high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-017 On acceptance, SHALL register addr/write/wdata into PADDR/PWRITE/PWDATA and go to SETUP the next cycle.
REQ-018 In SETUP, SHALL drive PSEL=1, PENABLE=0, then go unconditionally to ACCESS.
REQ-019 In ACCESS, SHALL drive PSEL=1, PENABLE=1 and hold PADDR/PWRITE/PWDATA stable until completion.
REQ-020 ACCESS SHALL complete on the first edge with PREADY=1; the FSM then returns to IDLE.
REQ-021 On completion, SHALL pulse rsp_valid for exactly one cycle, registered one cycle after the completing edge. rsp_rdata = PRDATA for a successful read, else 0. rsp_err = PSLVERR.
REQ-022 SHALL count consecutive ACCESS cycles with PREADY=0. When the count reaches TIMEOUT (TIMEOUT>0), SHALL terminate with rsp_err=1, rsp_rdata=0 and return to IDLE. The counter SHALL clear on entering ACCESS.
REQ-023 PREADY=1 on the same edge the counter reaches TIMEOUT SHALL be a normal completion; PREADY takes precedence.
REQ-024 PSEL and PENABLE SHALL be 0 in IDLE. PWDATA/PADDR SHALL retain their last values.
REQ-025 Minimum transfer cost SHALL be 3 cycles (accept, SETUP, ACCESS). A new request SHALL be accepted in the IDLE cycle following completion.
REQ-026 rsp_rdata/rsp_err SHALL hold their values until the next rsp_valid. There is no response backpressure.

Reset
REQ-027 While rst=1 at a clock edge, SHALL set: state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0; rsp_valid, rsp_err, rsp_rdata = 0; timeout counter = 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid; PSEL SHALL be 0 the cycle after the reset edge.
REQ-029 req_ready SHALL be 0 while rst=1.

Structure
REQ-030 SHALL define the FSM state enum (IDLE/SETUP/ACCESS) and the default width constants in a shared package, apb_pkg.
REQ-031 SHALL be a single module. The timeout counter MAY be a sub-module named apb_timeout_cnt.

Verification
REQ-032 Write: req addr=0x10, wdata=0x8000_0000, PREADY=1 -> PSEL high 2 cycles, PENABLE in the 2nd, PWDATA=0x8000_0000; rsp_valid pulse, rsp_err=0.
REQ-033 Read with wait states: PREADY low 3 ACCESS cycles, PRDATA=0x7FFF_FFFF -> PENABLE held 4 cycles, address stable; rsp_rdata=0x7FFF_FFFF.
REQ-034 Slave error: read, PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_rdata=0.
REQ-035 Timeout: TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then PSEL=0, rsp_err=1. Also PREADY=1 on the 4th cycle -> normal completion.
REQ-036 Reset during ACCESS: rst=1 for 1 cycle -> PSEL=0 next cycle, no rsp_valid, req_ready=1 after rst deasserts.
REQ-037 Back-to-back: req_valid held high for 2 writes -> second SETUP starts exactly one IDLE cycle after the first completion.
